// File: rtl/bcd_entry_to_bin.sv
// Two-digit keypad entry assembler: collects tens/ones digits, echoes them for the
// display, and converts to an 8-bit binary value (0-99) on enter.
module bcd_entry_to_bin #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       enter,
  input  logic       clear,
  output logic [7:0] value_out,
  output logic       value_valid,
  output logic [3:0] tens_place,
  output logic [3:0] ones_place,
  output logic       entry_error,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Counter only needs to reach TIMEOUT_CYCLES-2; expiry fires on the edge it would hit -1.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [7:0]      value_q, value_d;
  logic            value_valid_q, value_valid_d;
  logic            entry_error_q, entry_error_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            digit_legal;
  logic [7:0]      entry_bin;

  assign digit_legal = (digit_in <= 4'd9);
  // tens*10 built from shifts so no multiplier is inferred.
  assign entry_bin = ({4'b0, tens_q} << 3) + ({4'b0, tens_q} << 1) + {4'b0, ones_q};

  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    entry_error_d = 1'b0;
    timeout_d     = 1'b0;
    cnt_d         = cnt_q;

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (enter) begin
      cnt_d = '0;
      case (state_q)
        S_ONE: begin
          value_d       = {4'b0, ones_q};
          value_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
        S_TWO: begin
          value_d       = entry_bin;
          value_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
        default: entry_error_d = 1'b1;
      endcase
    end else if (digit_valid) begin
      cnt_d = '0;
      if (!digit_legal) begin
        entry_error_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            tens_d  = 4'd0;
            ones_d  = digit_in;
            state_d = S_ONE;
          end
          S_ONE: begin
            tens_d  = ones_q;
            ones_d  = digit_in;
            state_d = S_TWO;
          end
          default: entry_error_d = 1'b1;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_d == S_IDLE) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
      cnt_d  = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      value_q       <= 8'd0;
      value_valid_q <= 1'b0;
      entry_error_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      entry_error_q <= entry_error_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign value_out   = value_q;
  assign value_valid = value_valid_q;
  assign tens_place  = tens_q;
  assign ones_place  = ones_q;
  assign entry_error = entry_error_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Directed bench for bcd_entry_to_bin; committed values go through an expected queue.
module tb_bcd_entry_to_bin;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] value_out;
  logic       value_valid;
  logic [3:0] tens_place;
  logic [3:0] ones_place;
  logic       entry_error;
  logic       timeout;
  logic       busy;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  bcd_entry_to_bin #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in),
    .enter(enter), .clear(clear), .value_out(value_out), .value_valid(value_valid),
    .tens_place(tens_place), .ones_place(ones_place), .entry_error(entry_error),
    .timeout(timeout), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes; returns 1 time unit after the sampling edge.
  task automatic step(input logic dv, input logic [3:0] d, input logic en, input logic cl);
    digit_valid = dv;
    digit_in    = d;
    enter       = en;
    clear       = cl;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    enter       = 1'b0;
    clear       = 1'b0;
    digit_in    = 4'd0;
  endtask

  task automatic digit(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic commit(input logic [7:0] expv);
    exp_q.push_back(expv);
    step(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_digits(input string tag, input logic [3:0] t, input logic [3:0] o, input logic b);
    chk({tag, "_tens"}, {4'b0, tens_place}, {4'b0, t});
    chk({tag, "_ones"}, {4'b0, ones_place}, {4'b0, o});
    chk({tag, "_busy"}, {7'b0, busy}, {7'b0, b});
  endtask

  // scoreboard: every value_valid pulse consumes one expected commit
  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_exclusive", {7'b0, ($countones({value_valid, entry_error, timeout}) <= 1)}, 8'd1);
      if (value_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", {7'b0, value_valid}, 8'd0);
        end else begin
          chk("commit_value", value_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // reset
    idle(2);
    chk("rst_value", value_out, 8'd0);
    chk("rst_vv", {7'b0, value_valid}, 8'd0);
    chk("rst_err", {7'b0, entry_error}, 8'd0);
    chk("rst_to", {7'b0, timeout}, 8'd0);
    chk_digits("rst", 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    idle(1);

    // 9, 5, enter -> 95
    digit(4'd9);
    chk_digits("d9", 4'd0, 4'd9, 1'b1);
    digit(4'd5);
    chk_digits("d95", 4'd9, 4'd5, 1'b1);
    commit(8'd95);
    chk("e95_value", value_out, 8'h5F);
    chk("e95_vv", {7'b0, value_valid}, 8'd1);
    chk_digits("e95", 4'd0, 4'd0, 1'b0);
    idle(1);
    chk("e95_vv_low", {7'b0, value_valid}, 8'd0);
    chk("e95_hold", value_out, 8'd95);

    // single digit, then two, then zeros
    digit(4'd7);
    commit(8'd7);
    chk("e7_value", value_out, 8'd7);
    digit(4'd2);
    digit(4'd5);
    commit(8'd25);
    chk("e25_value", value_out, 8'd25);
    digit(4'd0);
    digit(4'd0);
    commit(8'd0);
    chk("e00_value", value_out, 8'd0);
    chk("e00_vv", {7'b0, value_valid}, 8'd1);

    // overflow third digit, then enter in idle
    digit(4'd1);
    digit(4'd2);
    digit(4'd3);
    chk("ovf_err", {7'b0, entry_error}, 8'd1);
    chk_digits("ovf", 4'd1, 4'd2, 1'b1);
    commit(8'd12);
    chk("e12_value", value_out, 8'd12);
    chk("e12_err", {7'b0, entry_error}, 8'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("idle_enter_err", {7'b0, entry_error}, 8'd1);
    chk("idle_enter_vv", {7'b0, value_valid}, 8'd0);
    chk("idle_enter_hold", value_out, 8'd12);

    // illegal digits, clear priority
    digit(4'hA);
    chk("illegal_idle_err", {7'b0, entry_error}, 8'd1);
    chk_digits("illegal_idle", 4'd0, 4'd0, 1'b0);
    digit(4'd4);
    digit(4'hF);
    chk("illegal_one_err", {7'b0, entry_error}, 8'd1);
    chk_digits("illegal_one", 4'd0, 4'd4, 1'b1);
    step(1'b1, 4'd8, 1'b1, 1'b1);
    chk("clear_wins_err", {7'b0, entry_error}, 8'd0);
    chk("clear_wins_vv", {7'b0, value_valid}, 8'd0);
    chk_digits("clear_wins", 4'd0, 4'd0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b1);
    chk("clear_idle_err", {7'b0, entry_error}, 8'd0);
    chk_digits("clear_idle", 4'd0, 4'd0, 1'b0);
    digit(4'd6);
    step(1'b1, 4'd7, 1'b1, 1'b0);
    exp_q.push_back(8'd6);
    idle(1);
    chk("enter_over_digit", value_out, 8'd6);

    // timeout: pulse on the 7th idle edge after the digit
    digit(4'd3);
    for (int i = 1; i < TO - 1; i++) begin
      idle(1);
      chk("to_early", {7'b0, timeout}, 8'd0);
    end
    chk("to_busy_before", {7'b0, busy}, 8'd1);
    idle(1);
    chk("to_pulse", {7'b0, timeout}, 8'd1);
    chk("to_vv", {7'b0, value_valid}, 8'd0);
    chk("to_hold", value_out, 8'd6);
    chk_digits("to", 4'd0, 4'd0, 1'b0);
    idle(1);
    chk("to_pulse_end", {7'b0, timeout}, 8'd0);

    // digit on the expiry edge restarts the count
    digit(4'd3);
    idle(TO - 2);
    digit(4'd5);
    chk("to_race_pulse", {7'b0, timeout}, 8'd0);
    chk_digits("to_race", 4'd3, 4'd5, 1'b1);
    idle(TO - 2);
    chk("to_race_early", {7'b0, timeout}, 8'd0);
    idle(1);
    chk("to_race_late", {7'b0, timeout}, 8'd1);
    idle(TO + 2);
    chk("idle_no_to", {7'b0, timeout}, 8'd0);

    // async reset mid-entry
    digit(4'd1);
    digit(4'd2);
    #3;
    rst = 1'b1;
    #1;
    chk_digits("arst", 4'd0, 4'd0, 1'b0);
    chk("arst_value", value_out, 8'd0);
    chk("arst_state", {6'b0, state_dbg}, 8'd0);
    #2;
    rst = 1'b0;
    digit(4'd6);
    chk_digits("post_rst", 4'd0, 4'd6, 1'b1);
    chk("post_rst_state", {6'b0, state_dbg}, 8'd1);
    step(1'b0, 4'd0, 1'b0, 1'b1);

    idle(2);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
